// File: rtl/dr_pkg.sv
// Dual-rail (NCL) rail encoding, classification helpers and the controller state type,
// shared by the serial-adder controller and its output synchronizer.
package dr_pkg;

    typedef logic [1:0] rail_t;

    // Bit 1 is the true rail, bit 0 the false rail; both high is never legal.
    localparam rail_t DR_NULL = 2'b00;
    localparam rail_t DR_D0   = 2'b01;
    localparam rail_t DR_D1   = 2'b10;
    localparam rail_t DR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_NULL,
        ST_DONE
    } dr_ctrl_state_t;

    function automatic rail_t dr_enc(input logic b);
        return b ? DR_D1 : DR_D0;
    endfunction

    function automatic logic dr_is_data(input rail_t r);
        return (r == DR_D0) || (r == DR_D1);
    endfunction

    function automatic logic dr_is_null(input rail_t r);
        return r == DR_NULL;
    endfunction

    function automatic logic dr_is_illegal(input rail_t r);
        return r == DR_ILL;
    endfunction

endpackage

// File: rtl/dr_sync.sv
// Multi-flop synchronizer for the asynchronous adder outputs, plus a previous-sample
// register so the controller only acts on a value that has held for two synced samples.
module dr_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         stable_o
);

    logic [W-1:0] chain_q [STAGES];
    logic [W-1:0] prev_q;

    // NOTE: this array is a handful of flops, not a RAM, so resetting it costs nothing and
    // guarantees the controller starts out seeing NULL; non-blocking updates make the loop a shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[STAGES-1];
        end
    end

    assign q_o      = chain_q[STAGES-1];
    assign stable_o = (chain_q[STAGES-1] == prev_q);

endmodule

// File: rtl/dr_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: feeds one dual-rail NCL full adder a DATA/NULL
// wavefront pair per bit, collects sum bits on completion and returns the word valid/ready.
module dr_serial_adder_ctrl
    import dr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_err,
    output logic             fa_en,
    output logic [1:0]       fa_a,
    output logic [1:0]       fa_b,
    output logic [1:0]       fa_c_in,
    input  logic [1:0]       fa_s,
    input  logic [1:0]       fa_c_out
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    dr_ctrl_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] next_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rail_t            rail_a_q, rail_a_d;
    rail_t            rail_b_q, rail_b_d;
    rail_t            rail_c_q, rail_c_d;
    logic             fa_en_q;

    logic [3:0] sync_val;
    logic       sync_stable;
    rail_t      s_sync;
    rail_t      c_sync;
    logic       outs_null;
    logic       ph_data_done;
    logic       ph_null_done;
    logic       ph_illegal;
    logic       ph_timeout;
    logic       accept;

    dr_sync #(
        .W      (4),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .d_i      ({fa_c_out, fa_s}),
        .q_o      (sync_val),
        .stable_o (sync_stable)
    );

    assign s_sync = sync_val[1:0];
    assign c_sync = sync_val[3:2];

    assign outs_null    = dr_is_null(s_sync) && dr_is_null(c_sync);
    assign ph_data_done = sync_stable && dr_is_data(s_sync) && dr_is_data(c_sync);
    assign ph_null_done = sync_stable && outs_null;
    assign ph_illegal   = sync_stable && (dr_is_illegal(s_sync) || dr_is_illegal(c_sync));
    assign ph_timeout   = (cnt_q == TIMEOUT_CNT);
    assign accept       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An illegal code outranks completion, and completion outranks a timeout in the same cycle.
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ph_illegal)        state_d = ST_DONE;
                else if (ph_data_done) state_d = ST_NULL;
                else if (ph_timeout)   state_d = ST_DONE;
            end
            ST_NULL: begin
                if (ph_illegal)        state_d = ST_DONE;
                else if (ph_null_done) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_DATA;
                else if (ph_timeout)   state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned;
    // a missed assignment in always_comb would otherwise infer a latch.
    always_comb begin : datapath_next
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        err_d    = err_q;
        idx_d    = idx_q;
        next_idx = idx_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        rail_a_d = DR_NULL;
        rail_b_d = DR_NULL;
        rail_c_d = DR_NULL;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    carry_d  = in_c;
                    sum_d    = '0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    rail_a_d = dr_enc(in_a[0]);
                    rail_b_d = dr_enc(in_b[0]);
                    rail_c_d = dr_enc(in_c);
                end
            end
            ST_DATA: begin
                if (ph_illegal) begin
                    err_d = 1'b1;
                end else if (ph_data_done) begin
                    sum_d[idx_q] = s_sync[1];
                    carry_d      = c_sync[1];
                    cnt_d        = '0;
                end else if (ph_timeout) begin
                    err_d = 1'b1;
                end else begin
                    rail_a_d = dr_enc(a_q[idx_q]);
                    rail_b_d = dr_enc(b_q[idx_q]);
                    rail_c_d = dr_enc(carry_q);
                end
            end
            ST_NULL: begin
                if (ph_illegal) begin
                    err_d = 1'b1;
                end else if (ph_null_done) begin
                    cnt_d = '0;
                    if (idx_q != LAST_IDX) begin
                        idx_d    = next_idx;
                        rail_a_d = dr_enc(a_q[next_idx]);
                        rail_b_d = dr_enc(b_q[next_idx]);
                        rail_c_d = dr_enc(carry_q);
                    end
                end else if (ph_timeout) begin
                    err_d = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (out_ready) err_d = 1'b0;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rail_a_q <= DR_NULL;
            rail_b_q <= DR_NULL;
            rail_c_q <= DR_NULL;
            fa_en_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rail_a_q <= rail_a_d;
            rail_b_q <= rail_b_d;
            rail_c_q <= rail_c_d;
            fa_en_q  <= 1'b1;
        end
    end

    // A new operand is only taken once the adder has fully returned to NULL.
    always_comb begin : output_logic
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: in_ready  = !rst && fa_en_q && outs_null;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_sum = sum_q;
    assign out_c   = carry_q;
    assign out_err = err_q;
    assign fa_en   = fa_en_q;
    assign fa_a    = rail_a_q;
    assign fa_b    = rail_b_q;
    assign fa_c_in = rail_c_q;

endmodule

// File: tb/tb_dr_serial_adder_ctrl.sv
// Self-checking bench: behavioural NCL full adder with 1-unit delay, fault injection on
// its outputs, and expected results computed with plain word-level arithmetic.
module tb_dr_serial_adder_ctrl;
    import dr_pkg::*;

    localparam int W       = 8;
    localparam int SS      = 2;
    localparam int TMO     = 255;
    localparam int PHASE   = SS + 2;
    localparam int TXN_LAT = 2 * W * PHASE;
    localparam int BUDGET  = 2000;
    localparam int M_NONE  = 0;
    localparam int M_TMO   = 1;
    localparam int M_ILL   = 2;
    localparam int M_RST   = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_c;
    logic         out_err;
    logic         fa_en;
    logic [1:0]   fa_a;
    logic [1:0]   fa_b;
    logic [1:0]   fa_c_in;
    logic [1:0]   fa_s;
    logic [1:0]   fa_c_out;

    logic [1:0] m_s = 2'b00;
    logic [1:0] m_c = 2'b00;
    logic       fault_s_en  = 1'b0;
    logic       fault_c_en  = 1'b0;
    logic [1:0] fault_s_val = 2'b00;
    logic [1:0] fault_c_val = 2'b00;

    int errors       = 0;
    int checks       = 0;
    int overlap_cnt  = 0;
    int data_fronts  = 0;
    int null_fronts  = 0;
    int mixed_cycles = 0;
    int fault_lat    = 0;

    dr_serial_adder_ctrl #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_err   (out_err),
        .fa_en     (fa_en),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_c_in   (fa_c_in),
        .fa_s      (fa_s),
        .fa_c_out  (fa_c_out)
    );

    always #5 clk = ~clk;

    // NCL full adder: outputs go DATA only when all inputs are DATA, NULL only when all are NULL.
    always @(posedge clk) begin
        #1;
        if (!fa_en || (fa_a == DR_NULL && fa_b == DR_NULL && fa_c_in == DR_NULL)) begin
            m_s <= DR_NULL;
            m_c <= DR_NULL;
        end else if (dr_is_data(fa_a) && dr_is_data(fa_b) && dr_is_data(fa_c_in)) begin
            m_s <= dr_enc(fa_a[1] ^ fa_b[1] ^ fa_c_in[1]);
            m_c <= dr_enc((fa_a[1] & fa_b[1]) | (fa_c_in[1] & (fa_a[1] ^ fa_b[1])));
        end
    end

    assign fa_s     = fault_s_en ? fault_s_val : m_s;
    assign fa_c_out = fault_c_en ? fault_c_val : m_c;

    always @(negedge clk) begin
        if (in_ready && out_valid) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            step();
            n++;
        end
        check(tag, 32'(in_ready), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_valid = 1'b1;
        wait_ready("accept_ready");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts wavefronts and cycles until out_valid, injecting the requested fault on the way.
    task automatic observe(input int mode, output int lat);
        logic prev_data;
        logic all_d;
        logic all_n;
        prev_data    = 1'b0;
        lat          = 0;
        data_fronts  = 0;
        null_fronts  = 0;
        mixed_cycles = 0;
        fault_lat    = -1;
        while (!out_valid && lat < BUDGET) begin
            all_d = dr_is_data(fa_a) && dr_is_data(fa_b) && dr_is_data(fa_c_in);
            all_n = (fa_a == DR_NULL) && (fa_b == DR_NULL) && (fa_c_in == DR_NULL);
            if (!all_d && !all_n) mixed_cycles++;
            if (all_d && !prev_data) begin
                data_fronts++;
                if (mode == M_ILL && data_fronts == 4) begin
                    fault_s_val = DR_ILL;
                    fault_s_en  = 1'b1;
                    fault_lat   = lat;
                end
                if (mode == M_RST && data_fronts == 5) begin
                    rst       = 1'b1;
                    fault_lat = lat;
                    break;
                end
            end
            if (all_n && prev_data) begin
                null_fronts++;
                if (mode == M_TMO && null_fronts == 1) begin
                    fault_c_val = DR_D0;
                    fault_c_en  = 1'b1;
                    fault_lat   = lat;
                end
            end
            if (all_d) prev_data = 1'b1;
            else if (all_n) prev_data = 1'b0;
            step();
            lat++;
        end
        if (mode != M_RST) check("result_within_budget", 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_err", 32'(out_err), 32'd0);
    endtask

    task automatic run_normal(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] total;
        int lat;
        total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        send(a, b, c);
        observe(M_NONE, lat);
        check("latency", lat, TXN_LAT);
        check("data_fronts", data_fronts, W);
        check("null_fronts", null_fronts, W);
        check("mixed_rails", mixed_cycles, 0);
        check("sum", 32'(out_sum), 32'(total[W-1:0]));
        check("carry_out", 32'(out_c), 32'(total[W]));
        check("err_clear", 32'(out_err), 32'd0);
        release_result();
        check("ready_after_release", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W:0]   total;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           lat;
        int           unstable;
        int           stuck;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_fa_en", 32'(fa_en), 32'd0);
        check("rst_rails", 32'({fa_a, fa_b, fa_c_in}), 32'd0);
        rst = 1'b0;
        step();
        check("en_after_release", 32'(fa_en), 32'd1);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        run_normal(8'h5A, 8'h3C, 1'b0);
        run_normal(8'hFF, 8'h01, 1'b1);

        // Result held under back-pressure while a new operand is offered.
        send(8'h81, 8'h7F, 1'b1);
        observe(M_NONE, lat);
        check("bp_sum", 32'(out_sum), 32'h01);
        check("bp_carry", 32'(out_c), 32'd1);
        in_a     = 8'h11;
        in_b     = 8'h22;
        in_valid = 1'b1;
        unstable = 0;
        repeat (20) begin
            step();
            if (!out_valid || out_sum !== 8'h01 || out_c !== 1'b1 || out_err !== 1'b0 || in_ready)
                unstable++;
        end
        check("bp_hold_stable", unstable, 0);
        in_valid = 1'b0;
        release_result();
        check("bp_ready_after_release", 32'(in_ready), 32'd1);

        // Carry output stuck at DATA0 through the first NULL phase.
        send(8'h00, 8'h00, 1'b0);
        observe(M_TMO, lat);
        check("tmo_latency", lat - fault_lat, TMO + 1);
        check("tmo_err", 32'(out_err), 32'd1);
        check("tmo_sum", 32'(out_sum), 32'd0);
        check("tmo_rails_null", 32'({fa_a, fa_b, fa_c_in}), 32'd0);
        release_result();
        stuck = 0;
        repeat (5) begin
            step();
            if (in_ready) stuck++;
        end
        check("tmo_ready_blocked", stuck, 0);
        fault_c_en = 1'b0;
        wait_ready("tmo_ready_recovers");

        // Illegal code on the sum output during bit 3 DATA.
        total = {1'b0, 8'h6B} + {1'b0, 8'h2D} + 9'd1;
        send(8'h6B, 8'h2D, 1'b1);
        observe(M_ILL, lat);
        check("ill_detect_latency", lat - fault_lat, PHASE);
        check("ill_err", 32'(out_err), 32'd1);
        check("ill_sum", 32'(out_sum), 32'({5'b0, total[2:0]}));
        check("ill_rails_null", 32'({fa_a, fa_b, fa_c_in}), 32'd0);
        fault_s_en = 1'b0;
        release_result();
        wait_ready("ill_ready_recovers");

        // Reset at bit 4 of a transfer, then a clean transfer.
        send(8'hC3, 8'h99, 1'b0);
        observe(M_RST, lat);
        check("rst_at_bit4", data_fronts, 5);
        step();
        check("midrst_rails_null", 32'({fa_a, fa_b, fa_c_in}), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_fa_en", 32'(fa_en), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        check("midrst_en_back", 32'(fa_en), 32'd1);
        run_normal(8'hC3, 8'h99, 1'b0);

        for (int k = 0; k < 8; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_normal(ra, rb, rc);
        end

        check("ready_valid_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dr_serial_adder_ctrl.md
# dr_serial_adder_ctrl

Clocked controller that performs WIDTH-bit addition bit-serially through one dual-rail NCL `full_adder` instance. It sits directly upstream and downstream of the adder:
- It accepts synchronous valid/ready operands.
- For each bit it drives DATA then NULL wavefronts onto the adder inputs, detects completion on the adder outputs, and collects the sum.
- It returns the result word over a valid/ready port.

## Interface
Parameters:
- `WIDTH`, 8: operand/sum width in bits.
- `SYNC_STAGES`, 2: synchronizer depth on adder outputs (≥2).
- `TIMEOUT`, 255: max cycles per wavefront phase before error.

Ports:
- `clk` in 1: the block's one clock.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: operand accept.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `in_c` in 1: carry in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result accept.
- `out_sum` out WIDTH: sum.
- `out_c` out 1: carry out.
- `out_err` out 1: result invalid (timeout or illegal rail code).
- `fa_en` out 1: adder enable.
- `fa_a` out 2: dual-rail a.
- `fa_b` out 2: dual-rail b.
- `fa_c_in` out 2: dual-rail c_in.
- `fa_s` in 2: dual-rail sum, async to `clk`.
- `fa_c_out` in 2: dual-rail carry, async to `clk`.

## Operation
Rail encoding:
- `2'b00` NULL, `2'b01` DATA0, `2'b10` DATA1, `2'b11` illegal.
- Bit 1 is the true rail.

States:
- IDLE: `in_ready` = 1 iff synced adder outputs are both NULL. On accept, latch operands and load bit index 0. Carry register takes `in_c`. Drive DATA for bit 0 on the same edge. Go to DATA.
- DATA: drive `fa_a`/`fa_b`/`fa_c_in` as the dual-rail of `a[i]`, `b[i]`, carry. On completion (both `fa_s` and `fa_c_out` synced-stable DATA):
  - `sum[i]` ← `fa_s[1]`, carry ← `fa_c_out[1]`.
  - Drive all-NULL; go to NULL.
- NULL: drive all-NULL. On synced-stable NULL on both outputs:
  - If i = WIDTH-1, go to DONE.
  - Else i+1; drive DATA for the next bit; go to DATA.
- DONE: `out_valid` = 1; `out_sum`/`out_c`/`out_err` held stable. On `out_ready`, clear `out_err` and go to IDLE.

Completion detection:
- "Synced-stable" means the current synchronized sample equals the previous synchronized sample and has the required class.
- Stable `2'b11` on either output sets `out_err` and goes to DONE with rails NULL.

Timeout:
- The phase counter resets on every DATA/NULL entry.
- Reaching TIMEOUT sets `out_err`, forces rails NULL, and goes to DONE.
- `out_sum` bits not yet computed read 0.

Enable: `fa_en` is a register, 0 in reset and 1 from the cycle after reset release.

## Timing
- Reset values: `in_ready` 0 during reset, `out_valid` 0, `out_sum` 0, `out_c` 0, `out_err` 0, `fa_en` 0, all `fa_*` rails NULL. Also state IDLE, counters and synchronizer flops 0.
- Reset mid-operation: abort immediately. No result is emitted and rails return to NULL on the next edge.
- Phase latency with a zero-delay adder is SYNC_STAGES+2 cycles (4 at default).
- Accept edge to `out_valid` rising is 2·WIDTH·(SYNC_STAGES+2) cycles (64 at defaults).
- `in_ready` and `out_valid` are never high together. No back-to-back accept is possible; IDLE lasts at least 1 cycle.
- `out_valid` holds indefinitely under `out_ready` = 0.
- Error result: `out_valid` rises the edge after detection.

## Structure
- Package `dr_pkg`:
  - `rail_t` (logic[1:0]).
  - Constants `DR_NULL`, `DR_D0`, `DR_D1`.
  - Functions `dr_enc(bit)`, `dr_is_data`, `dr_is_null`, `dr_is_illegal`.
  - State enum `dr_ctrl_state_t`.
- One sub-module, `dr_sync`: parameterized SYNC_STAGES flop chain plus previous-sample register. Outputs the synced value and a `stable` flag. It is instantiated once for the 4 adder output bits.

## Test plan
- Adder model with 1 ns delay, a = 8'h5A, b = 8'h3C, c = 0 → sum 8'h96, out_c 0, err 0. `out_valid` rises 64 cycles after accept.
- a = 8'hFF, b = 8'h01, c = 1 → sum 8'h01, out_c 1. Also check that every bit phase shows a NULL on all rails between DATA wavefronts.
- Adder output stuck at DATA0 on `fa_c_out` during a NULL phase → `out_err` = 1 at TIMEOUT+1 cycles into the phase. Then `in_ready` stays 0 until the output returns NULL.
- `fa_s` forced to 2'b11 during bit 3 DATA → `out_err` = 1. `out_sum[7:3]` = 0; rails NULL.
- `out_ready` held 0 for 20 cycles after `out_valid` → outputs stable, no new accept. `out_ready` = 1 → IDLE next cycle.
- `rst` asserted at bit 4 of a transfer → next cycle all rails NULL, `out_valid` 0, `fa_en` 0. The next transaction after release is computed correctly.
